// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - memory access size encoding, store FSM states and size helper
// Shared with the fetch unit so both agree on the size encoding.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_DONE  = 2'b10
  } store_state_e;

  // Reserved size maps to zero bytes; callers reject it before any write.
  function automatic logic [2:0] size_bytes(input mem_size_e size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_sel.sv
// rtl/store_lane_sel.sv - picks byte k of a right-justified store operand, MSB first
// Byte k of an n-byte store is data[8*(n-k)-1 : 8*(n-k-1)].
module store_lane_sel
  import cpu_mem_pkg::*;
#(
  parameter int MBUS_WIDTH = 8,
  parameter int MDR_WIDTH  = 32
) (
  input  logic [MDR_WIDTH-1:0]  data_i,
  input  mem_size_e             size_i,
  input  logic [1:0]            k_i,
  output logic [MBUS_WIDTH-1:0] byte_o
);

  logic [2:0] n_bytes;
  logic [2:0] lane;

  always_comb begin
    n_bytes = size_bytes(size_i);
    lane    = n_bytes - 3'd1 - {1'b0, k_i};
    byte_o  = '0;
    if (n_bytes != 3'd0) begin
      byte_o = MBUS_WIDTH'(data_i >> (MBUS_WIDTH * int'(lane)));
    end
  end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - byte-serial big-endian store engine with ready handshake
// Optional STORE_UNIT_ALIGN_CHECK_EN rejects misaligned halfword/word stores.
module store_unit
  import cpu_mem_pkg::*;
#(
  parameter int MBUS_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int MDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [MDR_WIDTH-1:0]  st_data,
  input  logic [1:0]            st_size,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [MBUS_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready
);

  store_state_e          state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [MDR_WIDTH-1:0]  data_q;
  mem_size_e             size_q;
  logic [1:0]            cnt_q;
  logic                  done_q;
  logic                  error_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_waddr_q;
  logic [MBUS_WIDTH-1:0] mem_wdata_q;

  mem_size_e             req_size;
  logic                  req_reject;
  logic                  idle;
  logic                  last_byte;
  logic [1:0]            lane_k;
  mem_size_e             lane_size;
  logic [MDR_WIDTH-1:0]  lane_data;
  logic [ADDR_WIDTH-1:0] lane_addr;
  logic [MBUS_WIDTH-1:0] lane_byte;

  assign req_size = mem_size_e'(st_size);
  assign idle     = (state_q == ST_IDLE);

  always_comb begin
    req_reject = (req_size == SIZE_RSVD);
`ifdef STORE_UNIT_ALIGN_CHECK_EN
    if ((req_size == SIZE_HALF) && st_addr[0]) req_reject = 1'b1;
    if ((req_size == SIZE_WORD) && (st_addr[1:0] != 2'b00)) req_reject = 1'b1;
`endif
  end

  // The lane path prepares the byte to present next: byte 0 of an incoming
  // request while idle, otherwise the byte after the one being accepted.
  assign lane_k    = idle ? 2'd0 : cnt_q + 2'd1;
  assign lane_size = idle ? req_size : size_q;
  assign lane_data = idle ? st_data : data_q;
  assign lane_addr = (idle ? st_addr : addr_q) + ADDR_WIDTH'(lane_k);
  assign last_byte = ({1'b0, cnt_q} == (size_bytes(size_q) - 3'd1));

  store_lane_sel #(
    .MBUS_WIDTH(MBUS_WIDTH),
    .MDR_WIDTH (MDR_WIDTH)
  ) u_lane_sel (
    .data_i(lane_data),
    .size_i(lane_size),
    .k_i   (lane_k),
    .byte_o(lane_byte)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      size_q      <= SIZE_BYTE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (write_enable) begin
            addr_q <= st_addr;
            data_q <= st_data;
            size_q <= req_size;
            cnt_q  <= '0;
            if (req_reject) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end else begin
              state_q     <= ST_WRITE;
              mem_we_q    <= 1'b1;
              mem_waddr_q <= lane_addr;
              mem_wdata_q <= lane_byte;
            end
          end
        end
        ST_WRITE: begin
          if (mem_ready) begin
            if (last_byte) begin
              state_q     <= ST_DONE;
              done_q      <= 1'b1;
              mem_we_q    <= 1'b0;
              mem_waddr_q <= '0;
              mem_wdata_q <= '0;
            end else begin
              cnt_q       <= cnt_q + 2'd1;
              mem_waddr_q <= lane_addr;
              mem_wdata_q <= lane_byte;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          mem_we_q    <= 1'b0;
          mem_waddr_q <= '0;
          mem_wdata_q <= '0;
        end
      endcase
    end
  end

  assign busy      = !idle;
  assign done      = done_q;
  assign error     = error_q;
  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - directed self-checking bench for store_unit
// Expected bytes, addresses and latencies are hand-computed constants.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        write_enable = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [1:0]  st_size = '0;
  logic        busy, done, error, mem_we;
  logic [31:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic        mem_ready = 1'b1;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic done_err = 1'b0;
  int stab_err = 0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_a = '0;
  logic [7:0]  prev_d = '0;
  logic [31:0] wa[$];
  logic [7:0]  wd[$];
  int          wc[$];
  int n, s0;
  logic [7:0] exp_w [4];

  store_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .write_enable(write_enable),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_size     (st_size),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory-side observer: logs accepted bytes and done pulses mid-cycle.
  always @(negedge clk) begin
    if (mem_we && mem_ready) begin
      wa.push_back(mem_waddr);
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
    end
    if (prev_stall && (!mem_we || mem_waddr !== prev_a || mem_wdata !== prev_d)) stab_err++;
    prev_stall = mem_we && !mem_ready;
    prev_a = mem_waddr;
    prev_d = mem_wdata;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = error;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s, output int acc);
    st_addr = a;
    st_data = d;
    st_size = s;
    write_enable = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    write_enable = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int s = done_cnt;
    int k = 0;
    while (done_cnt == s && k < max) begin
      tick();
      k++;
    end
    if (done_cnt == s) check("done_timeout", 0, 1);
  endtask

  task automatic check_wr(input string tag, input int i, input logic [31:0] a, input logic [7:0] d);
    if (wa.size() > i) begin
      check($sformatf("%s_addr%0d", tag, i), wa[i], a);
      check($sformatf("%s_data%0d", tag, i), wd[i], d);
    end else begin
      check($sformatf("%s_missing%0d", tag, i), 0, 1);
    end
  endtask

  initial begin
    // reset has priority over a simultaneous request
    reset_n = 1'b0;
    write_enable = 1'b1;
    st_addr = 32'h55;
    st_size = 2'b00;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_we", mem_we, 0);
    check("rst_waddr", mem_waddr, 0);
    check("rst_wdata", mem_wdata, 0);
    write_enable = 1'b0;
    reset_n = 1'b1;
    tick();

    // word store, mem_ready held high
    clear_log();
    exp_w = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    req(32'h100, 32'hDEADBEEF, 2'b10, n);
    wait_done(20);
    check("word_n", wa.size(), 4);
    for (int i = 0; i < 4; i++) check_wr("word", i, 32'h100 + i, exp_w[i]);
    if (wc.size() > 0) check("word_first_we", wc[0] - n, 0);
    check("word_done_lat", done_cyc - n, 4);
    check("word_err", done_err, 0);

    // halfword with two wait states per byte
    clear_log();
    stab_err = 0;
    s0 = done_cnt;
    mem_ready = 1'b0;
    req(32'h20, 32'h1234, 2'b01, n);
    tick(); tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick(); tick();
    mem_ready = 1'b1;
    wait_done(10);
    repeat (3) tick();
    check("half_n", wa.size(), 2);
    check_wr("half", 0, 32'h20, 8'h12);
    check_wr("half", 1, 32'h21, 8'h34);
    check("half_stable", stab_err, 0);
    check("half_done_once", done_cnt - s0, 1);

    // address wrap
    clear_log();
    req(32'hFFFFFFFF, 32'hA5, 2'b00, n);
    wait_done(10);
    req(32'hFFFFFFFE, 32'hBEEF, 2'b01, n);
    wait_done(10);
    check("wrap_n", wa.size(), 3);
    check_wr("wrap", 0, 32'hFFFFFFFF, 8'hA5);
    check_wr("wrap", 1, 32'hFFFFFFFE, 8'hBE);
    check_wr("wrap", 2, 32'hFFFFFFFF, 8'hEF);

    clear_log();
    req(32'hFFFFFFFF, 32'h1234, 2'b01, n);
    wait_done(10);
`ifdef STORE_UNIT_ALIGN_CHECK_EN
    check("wrapmis_n", wa.size(), 0);
    check("wrapmis_err", done_err, 1);
    check("wrapmis_lat", done_cyc - n, 0);
`else
    check("wrapmis_n", wa.size(), 2);
    check_wr("wrapmis", 0, 32'hFFFFFFFF, 8'h12);
    check_wr("wrapmis", 1, 32'h00000000, 8'h34);
    check("wrapmis_err", done_err, 0);
`endif

    // misaligned word
    clear_log();
    exp_w = '{8'h11, 8'h22, 8'h33, 8'h44};
    req(32'h102, 32'h11223344, 2'b10, n);
    wait_done(20);
`ifdef STORE_UNIT_ALIGN_CHECK_EN
    check("mis_n", wa.size(), 0);
    check("mis_err", done_err, 1);
    check("mis_lat", done_cyc - n, 0);
`else
    check("mis_n", wa.size(), 4);
    for (int i = 0; i < 4; i++) check_wr("mis", i, 32'h102 + i, exp_w[i]);
    check("mis_err", done_err, 0);
    check("mis_lat", done_cyc - n, 4);
`endif

    // reserved size is rejected
    clear_log();
    req(32'h40, 32'hAB, 2'b11, n);
    wait_done(10);
    check("rsvd_n", wa.size(), 0);
    check("rsvd_err", done_err, 1);
    check("rsvd_lat", done_cyc - n, 0);

    // request while busy is dropped
    clear_log();
    s0 = done_cnt;
    exp_w = '{8'h01, 8'h02, 8'h03, 8'h04};
    req(32'h180, 32'h01020304, 2'b10, n);
    tick();
    st_addr = 32'h200;
    st_data = 32'hFF;
    st_size = 2'b00;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    wait_done(20);
    repeat (3) tick();
    check("busy_n", wa.size(), 4);
    for (int i = 0; i < 4; i++) check_wr("busy", i, 32'h180 + i, exp_w[i]);
    check("busy_idle", busy, 0);
    check("busy_done_once", done_cnt - s0, 1);

    // back-to-back byte stores: n+2 = 3 cycles apart
    clear_log();
    st_addr = 32'h40;
    st_data = 32'h77;
    st_size = 2'b00;
    write_enable = 1'b1;
    tick(); tick(); tick(); tick();
    write_enable = 1'b0;
    wait_done(10);
    check("b2b_n", wa.size(), 2);
    check_wr("b2b", 0, 32'h40, 8'h77);
    check_wr("b2b", 1, 32'h40, 8'h77);
    if (wc.size() > 1) check("b2b_gap", wc[1] - wc[0], 3);

    // reset after the second byte of a word store
    clear_log();
    s0 = done_cnt;
    req(32'h300, 32'hCAFEBABE, 2'b10, n);
    tick(); tick();
    mem_ready = 1'b0;
    reset_n = 1'b0;
    tick();
    check("rstmid_busy", busy, 0);
    check("rstmid_we", mem_we, 0);
    check("rstmid_waddr", mem_waddr, 0);
    reset_n = 1'b1;
    mem_ready = 1'b1;
    repeat (6) tick();
    check("rstmid_n", wa.size(), 2);
    check_wr("rstmid", 0, 32'h300, 8'hCA);
    check_wr("rstmid", 1, 32'h301, 8'hFE);
    check("rstmid_no_done", done_cnt - s0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
